sys_cmd_initiator: RTL and testbench
====================================

# sys_cmd_initiator

Host-side command initiator for the system-control frame protocol. It accepts one command at a time from a local sequencer, serialises it into the byte frame the system controller decodes (0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands), and drives those bytes into the UART transmitter. For commands that return data, it waits for the single response byte from the UART receiver, then reports that byte or a timeout.

## Interface
- `data_width`, 8: width of frame bytes, operands and the response byte.
- `address_width`, 3: register-file address width. The address is zero-extended into its frame byte.
- `timeout_cycles`, 4096: number of cycles to wait for a response before giving up. Legal values are 1 to 65535.
- `clk` input 1: the single clock. All logic is rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: a command is offered.
- `cmd_ready` output 1: the block can accept a command.
- `cmd_type` input 2: 0 = write, 1 = read, 2 = ALU with operands, 3 = ALU without operands.
- `cmd_addr` input address_width: register address for write and read commands.
- `cmd_data` input data_width: write data, or operand A.
- `cmd_data_b` input data_width: operand B.
- `cmd_fun` input 4: ALU function code.
- `tx_data` output data_width: frame byte presented to the UART transmitter.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: the UART transmitter accepts the byte this cycle.
- `rx_data` input data_width: byte from the UART receiver.
- `rx_valid` input 1: single-cycle strobe marking a valid `rx_data`.
- `rsp_data` output data_width: captured response byte.
- `rsp_valid` output 1: one-cycle pulse when a response is captured.
- `rsp_timeout` output 1: one-cycle pulse when the response wait expires.
- `busy` output 1: high in any state other than IDLE.

## Operation
- **Command latch.** A command is accepted on a cycle where `cmd_valid` and `cmd_ready` are both high. On acceptance, all `cmd_*` fields are registered. Inputs may change afterwards without effect.
- **Frames sent, byte 0 first:**
  - type 0: 0xAA, {0, addr}, data. No response expected.
  - type 1: 0xBB, {0, addr}. One response byte.
  - type 2: 0xCC, data, data_b, {4'h0, fun}. One response byte.
  - type 3: 0xDD, {4'h0, fun}. One response byte.
- **States:**
  - IDLE: `cmd_ready` is 1. An accepted command moves the block to SEND with the byte index at 0.
  - SEND: `tx_valid` is 1 and `tx_data` is frame[index]. When `tx_ready` is high, the index increments. When the last byte is accepted:
    - type 0 returns to IDLE;
    - other types go to WAIT_RSP with the timeout counter cleared.
  - WAIT_RSP: the counter increments every cycle.
    - If `rx_valid` is high, `rx_data` is registered into `rsp_data`, `rsp_valid` pulses, and the block returns to IDLE.
    - Otherwise, when the counter reaches `timeout_cycles`-1, `rsp_timeout` pulses and the block returns to IDLE.
- The byte index is 2 bits and the timeout counter is 16 bits. Neither wraps within legal use.
- `rsp_data` holds its value until the next capture.

## Timing
- **Reset values:** every output is 0 (`cmd_ready`, `tx_data`, `tx_valid`, `rsp_data`, `rsp_valid`, `rsp_timeout`, `busy`). The state is IDLE, and the index and counter are 0.
- `cmd_ready` rises in the first cycle after `reset` falls.
- If a command is accepted in cycle T:
  - `busy` and `tx_valid` are high from T+1, with byte 0 on `tx_data`;
  - `cmd_ready` is low from T+1.
- While `tx_valid` is high and `tx_ready` is low, `tx_data` is held stable.
- Back-to-back accepts are allowed: with `tx_ready` held high, a 4-byte frame occupies cycles T+1 through T+4.
- If the last byte is accepted in cycle L:
  - type 0: IDLE and `cmd_ready` high at L+1;
  - other types: WAIT_RSP at L+1.
- If `rx_valid` is high in WAIT_RSP cycle R:
  - `rsp_valid` is high and `rsp_data` valid at R+1;
  - the block is IDLE at R+1.
- Timeout: with no `rx_valid`, `rsp_timeout` pulses exactly `timeout_cycles` cycles after WAIT_RSP entry, and the block is IDLE in that same cycle.
- **Boundary cases:**
  - `rx_valid` in any state other than WAIT_RSP, including cycle L itself, is ignored and dropped.
  - `rx_valid` in the expiry cycle: the response wins, and `rsp_timeout` does not pulse.
  - A second `rx_valid` after capture is dropped.
  - `cmd_valid` while busy is not accepted.
  - `reset` high mid-frame or mid-wait: on that edge all state returns to reset values, `tx_valid` drops, and the partial frame is abandoned. The next command restarts at byte 0.

## Test plan
- Write, addr=5, data=0x3C, `tx_ready` always high -> bytes AA, 05, 3C on consecutive cycles; `cmd_ready` back high one cycle after the last byte; no `rsp_*` pulse.
- Read, addr=2, with `tx_ready` toggling 1/0 -> bytes BB, 02, each held stable while stalled; `rx_data`=0x7E strobed 10 cycles into WAIT_RSP -> `rsp_valid`=1 and `rsp_data`=0x7E the next cycle.
- Type 2, A=0x12, B=0x34, fun=0x3 -> bytes CC, 12, 34, 03; response 0x46 -> `rsp_valid` with `rsp_data`=0x46.
- Type 3, fun=0xA, `timeout_cycles`=16, no response -> bytes DD, 0A; `rsp_timeout` pulses exactly 16 cycles after WAIT_RSP entry; `rsp_valid` stays 0.
- `rx_valid` in the expiry cycle with 0x55 -> `rsp_valid` with `rsp_data`=0x55 and no `rsp_timeout`; a stray `rx_valid` while IDLE -> no output change.
- `reset` asserted after the second byte of a type 2 frame -> all outputs 0 the next cycle; a new type 1 command then sends BB first.

Source files
------------

// File: rtl/sys_cmd_initiator.sv
// sys_cmd_initiator
// Host-side command initiator for the system-control frame protocol. Takes one
// command at a time, serialises it into the controller's byte frame, pushes the
// bytes into the UART transmitter and, for commands that return data, waits for
// the single response byte or a timeout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a command; cmd_ready high
// SEND     | presenting frame[idx] on tx_data until the transmitter takes it
// WAIT_RSP | counting cycles until rx_valid or timeout_cycles expire
module sys_cmd_initiator #(
    parameter int data_width     = 8,
    parameter int address_width  = 3,
    parameter int timeout_cycles = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_type,
    input  logic [address_width-1:0] cmd_addr,
    input  logic [data_width-1:0]    cmd_data,
    input  logic [data_width-1:0]    cmd_data_b,
    input  logic [3:0]               cmd_fun,
    output logic [data_width-1:0]    tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [data_width-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic [data_width-1:0]    rsp_data,
    output logic                     rsp_valid,
    output logic                     rsp_timeout,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam logic [15:0] tc_last = 16'(timeout_cycles - 1);

    state_t                   state;
    logic [1:0]               idx;
    logic [15:0]              cnt;
    logic [1:0]               lat_type;
    logic [address_width-1:0] lat_addr;
    logic [data_width-1:0]    lat_data;
    logic [data_width-1:0]    lat_data_b;
    logic [3:0]               lat_fun;

    // Byte at position idx of the frame for a given command.
    function automatic logic [data_width-1:0] frame_byte(
        input logic [1:0]               typ,
        input logic [address_width-1:0] addr,
        input logic [data_width-1:0]    a,
        input logic [data_width-1:0]    b,
        input logic [3:0]               fun,
        input logic [1:0]               i
    );
        logic [data_width-1:0] addr_b;
        logic [data_width-1:0] fun_b;
        logic [data_width-1:0] res;
        addr_b = data_width'(addr);
        fun_b  = data_width'(fun);
        res    = '0;
        case (typ)
            2'd0: begin
                case (i)
                    2'd0:    res = data_width'(8'hAA);
                    2'd1:    res = addr_b;
                    default: res = a;
                endcase
            end
            2'd1: res = (i == 2'd0) ? data_width'(8'hBB) : addr_b;
            2'd2: begin
                case (i)
                    2'd0:    res = data_width'(8'hCC);
                    2'd1:    res = a;
                    2'd2:    res = b;
                    default: res = fun_b;
                endcase
            end
            default: res = (i == 2'd0) ? data_width'(8'hDD) : fun_b;
        endcase
        return res;
    endfunction

    // Index of the final byte of each frame type.
    function automatic logic [1:0] last_index(input logic [1:0] typ);
        logic [1:0] res;
        case (typ)
            2'd0:    res = 2'd2;
            2'd2:    res = 2'd3;
            default: res = 2'd1;
        endcase
        return res;
    endfunction

    // Command FSM: latch, serialise, wait for response; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            lat_type    <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_data_b  <= '0;
            lat_fun     <= '0;
            cmd_ready   <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lat_type   <= cmd_type;
                        lat_addr   <= cmd_addr;
                        lat_data   <= cmd_data;
                        lat_data_b <= cmd_data_b;
                        lat_fun    <= cmd_fun;
                        idx        <= '0;
                        tx_data    <= frame_byte(cmd_type, cmd_addr, cmd_data,
                                                 cmd_data_b, cmd_fun, 2'd0);
                        tx_valid   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx == last_index(lat_type)) begin
                            tx_valid <= 1'b0;
                            idx      <= '0;
                            if (lat_type == 2'd0) begin
                                busy      <= 1'b0;
                                cmd_ready <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                cnt   <= '0;
                                state <= WAIT_RSP;
                            end
                        end else begin
                            idx     <= idx + 2'd1;
                            tx_data <= frame_byte(lat_type, lat_addr, lat_data,
                                                  lat_data_b, lat_fun, idx + 2'd1);
                        end
                    end
                end
                WAIT_RSP: begin
                    cnt <= cnt + 16'd1;
                    // A response in the expiry cycle takes priority over the timeout.
                    if (rx_valid) begin
                        rsp_data  <= rx_data;
                        rsp_valid <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == tc_last) begin
                        rsp_timeout <= 1'b1;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_cmd_initiator.sv
// Self-checking bench for sys_cmd_initiator: table of commands with expected
// frames/responses, scoreboard queues checked by a negedge monitor, plus
// hand-written reset and stray-strobe sequences.
module tb_sys_cmd_initiator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = '0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic [7:0] cmd_data_b = '0;
    logic [3:0] cmd_fun = '0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    localparam int TO = 16;

    sys_cmd_initiator #(
        .data_width    (8),
        .address_width (3),
        .timeout_cycles(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_data_b (cmd_data_b),
        .cmd_fun    (cmd_fun),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rsp_data   (rsp_data),
        .rsp_valid  (rsp_valid),
        .rsp_timeout(rsp_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      typ;
        logic [2:0]      addr;
        logic [7:0]      a;
        logic [7:0]      b;
        logic [3:0]      fun;
        int              len;
        logic [3:0][7:0] bytes;
        bit              stall;
        int              rsp_delay;  // -1: no response driven
        logic [7:0]      rsp_byte;
        bit              exp_to;
        bit              junk;       // offer cmds / rx strobes while busy
    } vec_t;

    typedef struct packed {
        logic       to;
        logic [7:0] d;
    } rsp_t;

    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];
    vec_t       vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every transmitted byte and every response pulse must
    // match the next expected entry.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                chk("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_sb", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            end
        end
        if (rsp_valid || rsp_timeout) begin
            if (exp_rsp.size() == 0) begin
                chk("rsp_unexpected", {30'h0, rsp_valid, rsp_timeout}, 32'h0);
            end else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_kind", {30'h0, rsp_valid, rsp_timeout}, {30'h0, ~e.to, e.to});
                if (!e.to) chk("rsp_sb_data", {24'h0, rsp_data}, {24'h0, e.d});
            end
        end
    end

    task automatic run_cmd(input vec_t v);
        int   sent;
        int   cyc;
        int   w;
        bit   tr;
        bit   last;
        rsp_t r;
        chk("ready_before_cmd", {31'h0, cmd_ready}, 32'h1);
        cmd_type   = v.typ;
        cmd_addr   = v.addr;
        cmd_data   = v.a;
        cmd_data_b = v.b;
        cmd_fun    = v.fun;
        cmd_valid  = 1'b1;
        for (int i = 0; i < v.len; i++) exp_tx.push_back(v.bytes[i]);
        if (v.exp_to) begin
            r.to = 1'b1; r.d = 8'h00; exp_rsp.push_back(r);
        end else if (v.rsp_delay >= 0) begin
            r.to = 1'b0; r.d = v.rsp_byte; exp_rsp.push_back(r);
        end
        tick();
        cmd_valid = 1'b0;
        chk("accept_state", {29'h0, busy, tx_valid, cmd_ready}, 32'h6);
        sent = 0;
        cyc  = 0;
        while (sent < v.len && cyc < 200) begin
            chk("tx_byte", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, v.bytes[sent]});
            tr = v.stall ? (cyc % 2 == 0) : 1'b1;
            tx_ready = tr;
            last = tr && (sent == v.len - 1);
            if (v.junk) begin
                cmd_valid = 1'b1;
                cmd_type  = 2'd0;
                cmd_addr  = 3'd6;
                cmd_data  = 8'h99;
                rx_valid  = last;
                rx_data   = 8'hEE;
            end
            tick();
            cmd_valid = 1'b0;
            rx_valid  = 1'b0;
            if (tr) sent++;
            cyc++;
        end
        tx_ready = 1'b1;
        if (v.typ == 2'd0) begin
            chk("write_done", {29'h0, cmd_ready, busy, tx_valid}, 32'h4);
        end else begin
            chk("wait_entry", {30'h0, busy, tx_valid}, 32'h2);
            w = 0;
            while (!(rsp_valid || rsp_timeout) && w < 100) begin
                rx_valid = (w == v.rsp_delay);
                rx_data  = v.rsp_byte;
                tick();
                rx_valid = 1'b0;
                w++;
            end
            chk("rsp_latency", w, v.exp_to ? TO : v.rsp_delay + 1);
            chk("rsp_timeout_flag", {31'h0, rsp_timeout}, {31'h0, v.exp_to});
            chk("idle_after_rsp", {30'h0, busy, cmd_ready}, 32'h1);
            if (v.junk) begin
                rx_valid = 1'b1;
                rx_data  = 8'hEE;
            end
            tick();
            rx_valid = 1'b0;
            chk("pulse_one_cycle", {30'h0, rsp_valid, rsp_timeout}, 32'h0);
            if (!v.exp_to) chk("rsp_data_hold", {24'h0, rsp_data}, {24'h0, v.rsp_byte});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vecs[0] = '{typ:2'd0, addr:3'd5, a:8'h3C, b:8'h00, fun:4'h0, len:3, bytes:32'h003C05AA,
                    stall:1'b0, rsp_delay:-1, rsp_byte:8'h00, exp_to:1'b0, junk:1'b0};
        vecs[1] = '{typ:2'd1, addr:3'd2, a:8'h00, b:8'h00, fun:4'h0, len:2, bytes:32'h000002BB,
                    stall:1'b1, rsp_delay:10, rsp_byte:8'h7E, exp_to:1'b0, junk:1'b0};
        vecs[2] = '{typ:2'd2, addr:3'd0, a:8'h12, b:8'h34, fun:4'h3, len:4, bytes:32'h033412CC,
                    stall:1'b0, rsp_delay:3, rsp_byte:8'h46, exp_to:1'b0, junk:1'b1};
        vecs[3] = '{typ:2'd3, addr:3'd0, a:8'h00, b:8'h00, fun:4'hA, len:2, bytes:32'h00000ADD,
                    stall:1'b0, rsp_delay:-1, rsp_byte:8'h00, exp_to:1'b1, junk:1'b0};
        vecs[4] = '{typ:2'd3, addr:3'd0, a:8'h00, b:8'h00, fun:4'h5, len:2, bytes:32'h000005DD,
                    stall:1'b0, rsp_delay:TO-1, rsp_byte:8'h55, exp_to:1'b0, junk:1'b0};
        vecs[5] = '{typ:2'd0, addr:3'd7, a:8'hFF, b:8'h00, fun:4'h0, len:3, bytes:32'h00FF07AA,
                    stall:1'b1, rsp_delay:-1, rsp_byte:8'h00, exp_to:1'b0, junk:1'b1};

        // Reset state and release.
        tick();
        tick();
        chk("reset_outputs", {tx_data, rsp_data, 11'h0, cmd_ready, tx_valid, rsp_valid, rsp_timeout, busy}, 32'h0);
        reset = 1'b0;
        chk("ready_low_at_release", {31'h0, cmd_ready}, 32'h0);
        tick();
        chk("ready_after_release", {31'h0, cmd_ready}, 32'h1);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Stray rx strobe while idle must not change outputs.
        rx_valid = 1'b1;
        rx_data  = 8'h11;
        tick();
        rx_valid = 1'b0;
        chk("stray_rx_no_pulse", {31'h0, rsp_valid}, 32'h0);
        tick();
        chk("stray_rx_hold", {23'h0, busy, rsp_data}, {23'h0, 1'b0, 8'h55});

        // Reset in the middle of a type 2 frame, after its second byte.
        exp_tx.push_back(8'hCC);
        exp_tx.push_back(8'h21);
        cmd_type   = 2'd2;
        cmd_data   = 8'h21;
        cmd_data_b = 8'h43;
        cmd_fun    = 4'h9;
        cmd_valid  = 1'b1;
        tx_ready   = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("third_byte_presented", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h43});
        tx_ready = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        tx_ready = 1'b1;
        chk("midframe_reset_outputs", {tx_data, rsp_data, 11'h0, cmd_ready, tx_valid, rsp_valid, rsp_timeout, busy}, 32'h0);
        tick();
        chk("ready_after_midreset", {31'h0, cmd_ready}, 32'h1);

        v = '{typ:2'd1, addr:3'd1, a:8'h00, b:8'h00, fun:4'h0, len:2, bytes:32'h000001BB,
              stall:1'b0, rsp_delay:0, rsp_byte:8'h5A, exp_to:1'b0, junk:1'b0};
        run_cmd(v);

        tick();
        tick();
        chk("tx_queue_drained", exp_tx.size(), 32'h0);
        chk("rsp_queue_drained", exp_rsp.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
